alu_writeback: RTL and testbench
================================

# alu_writeback

Downstream result stage of the ALU. Captures the 8-bit result of whichever functional unit (suma, complemento, shiftl, shiftR, compc, compn, load) signals `done_*`. Queues each result with its 3-bit opcode tag in a small FIFO and drains the queue to the result memory through a write-request/acknowledge handshake. This decouples single-cycle unit completion from a memory that may stall.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `RES_BASE`, 8'hF0: base address of the result area; write address = `RES_BASE + tag`, modulo 256.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `done_suma`, `done_complemento`, `done_shiftl`, `done_shiftR`, `done_compc`, `done_compn`, `done_load` input 1 each: one-cycle completion pulses. Tags are 0, 1, 2, 3, 4, 5, 7 respectively; tag 6 is unused.
- `res_suma`, `res_complemento`, `res_shiftl`, `res_shiftR`, `res_compc`, `res_compn`, `res_load` input 8 each: unit results, valid in the cycle of the matching done.
- `mem_ack` input 1: memory accepted the current write.
- `wr` output 1: write request.
- `addr` output 8: write address.
- `data_out` output 8: write data.
- `wb_done` output 1: one-cycle pulse per completed write.
- `busy` output 1: FIFO non-empty or write in flight.
- `overflow` output 1: sticky; a result was dropped because the FIFO was full.
- `collision` output 1: sticky; more than one done was high in the same cycle.

## Operation
**Capture**
- Each cycle, at most one result is enqueued.
- If several dones are high together, the lowest tag wins: suma > complemento > shiftl > shiftR > compc > compn > load. The others are discarded and `collision` is set.
- Push is blocked when the FIFO is full and no pop happens in the same cycle. The result is dropped and `overflow` is set.
- Push and pop in the same cycle are legal at any occupancy, including full.
- Entry format: {tag[2:0], data[7:0]}. Read and write pointers wrap modulo `DEPTH`. A separate count (0..`DEPTH`) distinguishes full from empty.

**Write FSM**
- States: IDLE and WRITE.
- IDLE: `wr`=0. If count>0 at the edge, go to WRITE and load `addr`/`data_out` from the head entry.
- WRITE: `wr`=1, with `addr`/`data_out` held stable until `mem_ack` is sampled high.
- On an ack edge: pop the head and pulse `wb_done` next cycle. If the post-update count (pop plus any simultaneous push) is greater than 0, stay in WRITE and present the new head next cycle (back-to-back writes). Otherwise return to IDLE.
- `mem_ack` while in IDLE is ignored.

**Other rules**
- `busy` = (count != 0) | (state == WRITE).
- Flags `overflow` and `collision` clear only on `rst`.

## Timing
- Reset values: `wr`=0, `addr`=0, `data_out`=0, `wb_done`=0, `busy`=0, `overflow`=0, `collision`=0, FSM in IDLE, pointers and count 0.
- Latency, done to write request: a done in cycle N (FIFO empty, IDLE) gives `wr`=1 with that data in cycle N+2.
- Ack to next write: ack sampled at edge E gives the next entry on `addr`/`data_out` from cycle E+1 with `wr` still high. `wb_done` is high in cycle E+1 only.
- Minimum one cycle per write. Sustained throughput is 1 write/cycle with `mem_ack` tied high.
- Rest state: with an empty FIFO and no dones, the block returns to `wr`=0 one cycle after the last ack.
- Reset mid-write: `rst` high at any edge returns every output to its reset value on that edge. All queued entries and the in-flight write are discarded, with no `wb_done`.

## Test plan
- **Single result:** `done_suma` with `res_suma`=8'h3C, `mem_ack` tied 1 → `wr`=1, `addr`=8'hF0, `data_out`=8'h3C two cycles later for one cycle. `wb_done` pulses the next cycle; `busy` returns to 0.
- **Stalled memory, fill and overflow:** `mem_ack`=0; dones on tags 1, 2, 3, 4, 5 on consecutive cycles with data 8'h11..8'h55 → `wr` holds `addr` 8'hF1 / 8'h11. The fifth push (tag 5) sets `overflow`. Releasing `mem_ack` writes exactly F1/11, F2/22, F3/33, F4/44, back-to-back.
- **Collision:** `done_shiftR`(8'hAA) and `done_load`(8'hBB) in the same cycle → only `addr` 8'hF3 / 8'hAA is written, and `collision` goes to 1 and stays.
- **Full with simultaneous push/pop:** FIFO full, ack and a new done (`done_compn`, 8'h5E) in the same cycle → no overflow; the compn entry is written last at `addr` 8'hF5.
- **Reset mid-write:** 3 entries queued, `wr` high, `mem_ack`=0; assert `rst` one cycle → all outputs zero next cycle. No further writes occur after `rst` deasserts without new dones.
- **Base wrap:** `RES_BASE`=8'hFE, `done_load`(8'h01) → `addr`=8'h05.

Source files
------------

// File: rtl/alu_writeback.sv
// ALU result writeback stage: captures unit completions into a tagged FIFO and
// drains it to result memory through a wr/mem_ack handshake.
module alu_writeback #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [7:0]  RES_BASE = 8'hF0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done_suma,
  input  logic       done_complemento,
  input  logic       done_shiftl,
  input  logic       done_shiftR,
  input  logic       done_compc,
  input  logic       done_compn,
  input  logic       done_load,
  input  logic [7:0] res_suma,
  input  logic [7:0] res_complemento,
  input  logic [7:0] res_shiftl,
  input  logic [7:0] res_shiftR,
  input  logic [7:0] res_compc,
  input  logic [7:0] res_compn,
  input  logic [7:0] res_load,
  input  logic       mem_ack,
  output logic       wr,
  output logic [7:0] addr,
  output logic [7:0] data_out,
  output logic       wb_done,
  output logic       busy,
  output logic       overflow,
  output logic       collision,
  output logic       dbg_state_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Handshake: wr stays high with addr/data_out stable until mem_ack is
  // sampled high on a rising edge; that edge completes the transfer.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [10:0]    mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     addr_q, addr_d;
  logic [7:0]     data_q, data_d;
  logic           wb_done_q, wb_done_d;
  logic           overflow_q, overflow_d;
  logic           collision_q, collision_d;

  logic [6:0]     done_vec;
  logic           push_req, push, pop, full, multi;
  logic [2:0]     push_tag;
  logic [7:0]     push_data;
  logic [10:0]    head_entry, next_entry;
  logic           load_head, load_next;

  assign done_vec = {done_load, done_compn, done_compc, done_shiftR,
                     done_shiftl, done_complemento, done_suma};

  // Lowest tag wins when several units complete together.
  always_comb begin
    push_tag  = 3'd0;
    push_data = 8'h00;
    casez (done_vec)
      7'b??????1: begin push_tag = 3'd0; push_data = res_suma;        end
      7'b?????10: begin push_tag = 3'd1; push_data = res_complemento; end
      7'b????100: begin push_tag = 3'd2; push_data = res_shiftl;      end
      7'b???1000: begin push_tag = 3'd3; push_data = res_shiftR;      end
      7'b??10000: begin push_tag = 3'd4; push_data = res_compc;       end
      7'b?100000: begin push_tag = 3'd5; push_data = res_compn;       end
      7'b1000000: begin push_tag = 3'd7; push_data = res_load;        end
      default:    begin push_tag = 3'd0; push_data = 8'h00;           end
    endcase
  end

  assign push_req = |done_vec;
  assign multi    = (done_vec & (done_vec - 7'd1)) != 7'd0;
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = (state_q == S_WRITE) && mem_ack;
  assign push     = push_req && (!full || pop);
  assign count_d  = count_q + CW'(push) - CW'(pop);

  // After a pop the new head is the next stored entry, or the entry being
  // pushed this very cycle when the queue held only the one being written.
  assign head_entry = mem_q[rd_ptr_q];
  assign next_entry = (count_q > CW'(1)) ? mem_q[rd_ptr_q + PW'(1)]
                                         : {push_tag, push_data};

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_tag, push_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    load_next = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d   = S_WRITE;
          load_head = 1'b1;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          if (count_d != '0) load_next = 1'b1;
          else               state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    wr          = (state_q == S_WRITE);
    busy        = (count_q != '0) || (state_q == S_WRITE);
    dbg_state_o = state_q;
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (load_head) begin
      addr_d = RES_BASE + {5'b00000, head_entry[10:8]};
      data_d = head_entry[7:0];
    end else if (load_next) begin
      addr_d = RES_BASE + {5'b00000, next_entry[10:8]};
      data_d = next_entry[7:0];
    end
    wb_done_d   = pop;
    overflow_d  = overflow_q | (push_req && full && !pop);
    collision_d = collision_q | multi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      wb_done_q   <= 1'b0;
      overflow_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      data_q      <= data_d;
      wb_done_q   <= wb_done_d;
      overflow_q  <= overflow_d;
      collision_q <= collision_d;
    end
  end

  assign addr      = addr_q;
  assign data_out  = data_q;
  assign wb_done   = wb_done_q;
  assign overflow  = overflow_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: priority/address table, directed multi-cycle
// sequences, and a randomized run against a queue-based reference model.
module tb_alu_writeback;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] done_v;
  logic [7:0] res_v [7];
  logic       mem_ack;
  logic       wr, wb_done, busy, overflow, collision, dbg_state;
  logic [7:0] addr, data_out;
  logic       wr2, wb_done2, busy2, overflow2, collision2, dbg_state2;
  logic [7:0] addr2, data_out2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_writeback #(.DEPTH(DEPTH), .RES_BASE(8'hF0)) u_dut (
    .clk(clk), .rst(rst),
    .done_suma(done_v[0]), .done_complemento(done_v[1]), .done_shiftl(done_v[2]),
    .done_shiftR(done_v[3]), .done_compc(done_v[4]), .done_compn(done_v[5]),
    .done_load(done_v[6]),
    .res_suma(res_v[0]), .res_complemento(res_v[1]), .res_shiftl(res_v[2]),
    .res_shiftR(res_v[3]), .res_compc(res_v[4]), .res_compn(res_v[5]),
    .res_load(res_v[6]),
    .mem_ack(mem_ack), .wr(wr), .addr(addr), .data_out(data_out),
    .wb_done(wb_done), .busy(busy), .overflow(overflow), .collision(collision),
    .dbg_state_o(dbg_state)
  );

  alu_writeback #(.DEPTH(DEPTH), .RES_BASE(8'hFE)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .done_suma(done_v[0]), .done_complemento(done_v[1]), .done_shiftl(done_v[2]),
    .done_shiftR(done_v[3]), .done_compc(done_v[4]), .done_compn(done_v[5]),
    .done_load(done_v[6]),
    .res_suma(res_v[0]), .res_complemento(res_v[1]), .res_shiftl(res_v[2]),
    .res_shiftR(res_v[3]), .res_compc(res_v[4]), .res_compn(res_v[5]),
    .res_load(res_v[6]),
    .mem_ack(mem_ack), .wr(wr2), .addr(addr2), .data_out(data_out2),
    .wb_done(wb_done2), .busy(busy2), .overflow(overflow2), .collision(collision2),
    .dbg_state_o(dbg_state2)
  );

  typedef struct {
    logic [6:0] dones;
    logic [7:0] base;
    logic [7:0] exp_addr;
    logic [7:0] exp_data;
    logic       exp_col;
  } vec_t;

  vec_t vecs [7];

  // Reference model state
  logic [10:0] m_q[$];
  bit          m_wr, m_wb, m_ovf, m_col;
  logic [7:0]  m_addr, m_data;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    done_v  = '0;
    mem_ack = 1'b0;
    for (int i = 0; i < 7; i++) res_v[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    rst = 1'b0;
    m_q.delete();
    m_wr = 0; m_wb = 0; m_ovf = 0; m_col = 0;
    m_addr = 8'h00; m_data = 8'h00;
  endtask

  // One-cycle completion pulse for unit index u (tags 0..5, load -> 7).
  task automatic pulse(input int u, input logic [7:0] d);
    done_v    = '0;
    done_v[u] = 1'b1;
    res_v[u]  = d;
    cyc();
    done_v = '0;
  endtask

  function automatic logic [2:0] tag_of(input int u);
    return (u == 6) ? 3'd7 : 3'(u);
  endfunction

  // Spec-level model: queue of pending {tag,data}; the head is what is on the bus.
  task automatic model_step();
    logic [10:0] nq[$];
    logic [10:0] h;
    bit pop;
    int nd;
    int first;
    pop = m_wr && mem_ack;
    nd  = $countones(done_v);
    nq  = m_q;
    if (pop) void'(nq.pop_front());
    if (nd > 1) m_col = 1;
    if (nd > 0) begin
      first = 0;
      while (!done_v[first]) first++;
      if (m_q.size() == DEPTH && !pop) m_ovf = 1;
      else nq.push_back({tag_of(first), res_v[first]});
    end
    m_wb = pop;
    if (!m_wr) begin
      if (m_q.size() > 0) begin
        h = m_q[0];
        m_wr = 1; m_addr = 8'hF0 + {5'b0, h[10:8]}; m_data = h[7:0];
      end
    end else if (pop) begin
      if (nq.size() > 0) begin
        h = nq[0];
        m_addr = 8'hF0 + {5'b0, h[10:8]}; m_data = h[7:0];
      end else begin
        m_wr = 0;
      end
    end
    m_q = nq;
  endtask

  task automatic check_model();
    chk("rnd_wr", wr, m_wr);
    chk("rnd_state", dbg_state, m_wr);
    if (m_wr) begin
      chk("rnd_addr", addr, m_addr);
      chk("rnd_data", data_out, m_data);
    end
    chk("rnd_wb_done", wb_done, m_wb);
    chk("rnd_busy", busy, (m_q.size() != 0) || m_wr);
    chk("rnd_overflow", overflow, m_ovf);
    chk("rnd_collision", collision, m_col);
  endtask

  initial begin
    vecs[0] = '{7'b0000001, 8'h10, 8'hF0, 8'h10, 1'b0};
    vecs[1] = '{7'b0000010, 8'h20, 8'hF1, 8'h21, 1'b0};
    vecs[2] = '{7'b1000000, 8'h30, 8'hF7, 8'h36, 1'b0};
    vecs[3] = '{7'b0100000, 8'h40, 8'hF5, 8'h45, 1'b0};
    vecs[4] = '{7'b1100000, 8'h50, 8'hF5, 8'h55, 1'b1};
    vecs[5] = '{7'b1010100, 8'h60, 8'hF2, 8'h62, 1'b1};
    vecs[6] = '{7'b0001000, 8'h70, 8'hF3, 8'h73, 1'b0};

    rst = 1'b1;
    clear_inputs();
    do_reset();

    // Reset state
    chk("rst_wr", wr, 1'b0);
    chk("rst_addr", addr, 8'h00);
    chk("rst_data", data_out, 8'h00);
    chk("rst_wb_done", wb_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_collision", collision, 1'b0);

    // Single result, ack tied high
    mem_ack = 1'b1;
    pulse(0, 8'h3C);
    chk("single_wr_n1", wr, 1'b0);
    chk("single_busy_n1", busy, 1'b1);
    cyc();
    chk("single_wr", wr, 1'b1);
    chk("single_addr", addr, 8'hF0);
    chk("single_data", data_out, 8'h3C);
    chk("single_wb_early", wb_done, 1'b0);
    cyc();
    chk("single_wr_off", wr, 1'b0);
    chk("single_wb_done", wb_done, 1'b1);
    chk("single_busy_off", busy, 1'b0);
    cyc();
    chk("single_wb_once", wb_done, 1'b0);

    // Priority and address table
    for (int v = 0; v < 7; v++) begin
      do_reset();
      mem_ack = 1'b1;
      for (int i = 0; i < 7; i++) res_v[i] = vecs[v].base + 8'(i);
      done_v = vecs[v].dones;
      cyc();
      done_v = '0;
      cyc();
      chk($sformatf("vec%0d_wr", v), wr, 1'b1);
      chk($sformatf("vec%0d_addr", v), addr, vecs[v].exp_addr);
      chk($sformatf("vec%0d_data", v), data_out, vecs[v].exp_data);
      chk($sformatf("vec%0d_col", v), collision, vecs[v].exp_col);
      cyc();
      chk($sformatf("vec%0d_single", v), wr, 1'b0);
    end

    // Stalled memory: fill and overflow
    do_reset();
    mem_ack = 1'b0;
    for (int u = 1; u <= 5; u++) pulse(u, 8'(u * 8'h11));
    chk("stall_overflow", overflow, 1'b1);
    chk("stall_wr", wr, 1'b1);
    chk("stall_addr", addr, 8'hF1);
    chk("stall_data", data_out, 8'h11);
    mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_wr", k), wr, 1'b1);
      chk($sformatf("drain%0d_addr", k), addr, 8'hF1 + 8'(k));
      chk($sformatf("drain%0d_data", k), data_out, 8'(8'h11 * (k + 1)));
      cyc();
      chk($sformatf("drain%0d_wb", k), wb_done, 1'b1);
    end
    chk("drain_end_wr", wr, 1'b0);
    chk("drain_end_busy", busy, 1'b0);

    // Collision
    do_reset();
    mem_ack = 1'b1;
    res_v[3] = 8'hAA; res_v[6] = 8'hBB;
    done_v = 7'b1001000;
    cyc();
    done_v = '0;
    chk("col_flag", collision, 1'b1);
    cyc();
    chk("col_wr", wr, 1'b1);
    chk("col_addr", addr, 8'hF3);
    chk("col_data", data_out, 8'hAA);
    cyc();
    chk("col_one_write", wr, 1'b0);
    cyc(); cyc();
    chk("col_sticky", collision, 1'b1);
    chk("col_idle", busy, 1'b0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    mem_ack = 1'b0;
    for (int u = 0; u < 4; u++) pulse(u, 8'(u + 1));
    chk("full_head_addr", addr, 8'hF0);
    mem_ack = 1'b1;
    pulse(5, 8'h5E);
    chk("full_no_overflow", overflow, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("full%0d_wr", k), wr, 1'b1);
      chk($sformatf("full%0d_addr", k), addr, (k == 3) ? 8'hF5 : 8'hF1 + 8'(k));
      chk($sformatf("full%0d_data", k), data_out, (k == 3) ? 8'h5E : 8'(k + 2));
      cyc();
    end
    chk("full_end_wr", wr, 1'b0);

    // Reset mid-write
    do_reset();
    mem_ack = 1'b0;
    res_v[0] = 8'hA0; res_v[1] = 8'hA1;
    done_v = 7'b0000011;
    cyc();
    pulse(2, 8'hA2);
    pulse(3, 8'hA3);
    chk("mid_wr", wr, 1'b1);
    chk("mid_col", collision, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_wr", wr, 1'b0);
    chk("mid_rst_addr", addr, 8'h00);
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_wb", wb_done, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_col", collision, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    mem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("post_rst%0d_wr", k), wr, 1'b0);
      chk($sformatf("post_rst%0d_wb", k), wb_done, 1'b0);
    end

    // Base address wrap on the second instance
    do_reset();
    mem_ack = 1'b1;
    pulse(6, 8'h01);
    cyc();
    chk("wrap_wr", wr2, 1'b1);
    chk("wrap_addr", addr2, 8'h05);
    chk("wrap_data", data_out2, 8'h01);

    // Randomized run against the reference model
    do_reset();
    begin
      int ack_pct;
      int r;
      ack_pct = 50;
      for (int c = 0; c < 3000; c++) begin
        if (c % 250 == 0) ack_pct = $urandom_range(0, 100);
        r = $urandom_range(0, 9);
        done_v = '0;
        if (r >= 9) done_v = 7'($urandom_range(0, 127));
        else if (r >= 4) done_v[$urandom_range(0, 6)] = 1'b1;
        for (int i = 0; i < 7; i++) res_v[i] = 8'($urandom_range(0, 255));
        mem_ack = ($urandom_range(0, 99) < ack_pct);
        model_step();
        cyc();
        check_model();
        if (c == 1500) begin
          do_reset();
          check_model();
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
